// File: rtl/instr_sequencer_if.sv
// Bundle of the sequencer's run control, instruction-memory, execute-unit and PC signals.
//   master : sequencer side (drives imem_req/imem_addr, instr/instr_valid, pc_* and status)
//   slave  : environment side (drives run, pc_addr, imem_ack/imem_rdata, exec_done, br_*)
interface instr_sequencer_if #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned INSTR_W = 16
);
  logic               run;
  logic [ADDR_W-1:0]  pc_addr;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               exec_done;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic               pc_en;
  logic               pc_branch_en;
  logic [ADDR_W-1:0]  pc_next_addr;
  logic               halted;
  logic               fault;

  modport master (
    input  run, pc_addr, imem_ack, imem_rdata, exec_done, br_taken, br_target,
    output imem_req, imem_addr, instr, instr_valid, pc_en, pc_branch_en, pc_next_addr,
           halted, fault
  );

  modport slave (
    output run, pc_addr, imem_ack, imem_rdata, exec_done, br_taken, br_target,
    input  imem_req, imem_addr, instr, instr_valid, pc_en, pc_branch_en, pc_next_addr,
           halted, fault
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer driving the program counter's en / branch_en / next-address inputs.
// Each instruction runs IDLE/ADVANCE -> FETCH (req/ack with memory) -> EXEC (wait for the
// execute unit) -> ADVANCE (one pc_en pulse, increment or branch). A fetch that sees no ack
// for WAIT_MAX cycles parks the sequencer in a sticky FAULT state until rst.
// Ports:
//   clk, rst : clock and synchronous active-high reset (shared with the PC)
//   step     : single-step request, present only when SEQ_SINGLE_STEP_EN is defined
//   bus      : instr_sequencer_if.master (run, PC, memory, execute-unit and status signals)
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds the step port; default build omits it).
module instr_sequencer #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned WAIT_MAX = 15
) (
  input logic              clk,
  input logic              rst,
`ifdef SEQ_SINGLE_STEP_EN
  input logic              step,
`endif
  instr_sequencer_if.master bus
);

  localparam int unsigned CntW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StAdvance, StFault} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    wait_cnt_q, wait_cnt_d;
  logic               step_mode_q, step_mode_d;
  logic               step_start;
  logic               imem_req_q;
  logic [INSTR_W-1:0] instr_q;
  logic               instr_valid_q;
  logic               pc_en_q;
  logic               pc_branch_en_q;
  logic [ADDR_W-1:0]  pc_next_addr_q;
  logic               halted_q;
  logic               fault_q;

`ifdef SEQ_SINGLE_STEP_EN
  assign step_start = step & ~bus.run;
`else
  assign step_start = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    step_mode_d = step_mode_q;
    unique case (state_q)
      StIdle: begin
        if (bus.run) begin
          state_d     = StFetch;
          wait_cnt_d  = '0;
          step_mode_d = 1'b0;
        end else if (step_start) begin
          state_d     = StFetch;
          wait_cnt_d  = '0;
          step_mode_d = 1'b1;
        end
      end
      StFetch: begin
        // An ack on the last allowed cycle beats the timeout.
        if (bus.imem_ack) begin
          state_d = StExec;
        end else if (WAIT_MAX != 0) begin
          if (wait_cnt_q == CntW'(WAIT_MAX - 1)) begin
            state_d = StFault;
          end else begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
          end
        end
      end
      StExec: begin
        if (bus.exec_done) state_d = StAdvance;
      end
      StAdvance: begin
        if (bus.run && !step_mode_q) begin
          state_d    = StFetch;
          wait_cnt_d = '0;
        end else begin
          state_d     = StIdle;
          step_mode_d = 1'b0;
        end
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      wait_cnt_q     <= '0;
      step_mode_q    <= 1'b0;
      imem_req_q     <= 1'b0;
      instr_q        <= '0;
      instr_valid_q  <= 1'b0;
      pc_en_q        <= 1'b0;
      pc_branch_en_q <= 1'b0;
      pc_next_addr_q <= '0;
      halted_q       <= 1'b1;
      fault_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      step_mode_q   <= step_mode_d;
      imem_req_q    <= (state_d == StFetch);
      instr_valid_q <= (state_q == StFetch) && (state_d == StExec);
      pc_en_q       <= (state_d == StAdvance);
      halted_q      <= (state_d == StIdle) || (state_d == StFault);
      fault_q       <= (state_d == StFault);
      if ((state_q == StFetch) && bus.imem_ack) instr_q <= bus.imem_rdata;
      // Branch info is captured with exec_done and presented only during ADVANCE.
      if ((state_q == StExec) && bus.exec_done) begin
        pc_branch_en_q <= bus.br_taken;
        pc_next_addr_q <= bus.br_taken ? bus.br_target : '0;
      end else begin
        pc_branch_en_q <= 1'b0;
        pc_next_addr_q <= '0;
      end
    end
  end

  // The PC updates on the edge that ends ADVANCE, so the address is passed through (gated by
  // the registered req) to let the very first FETCH cycle present the updated PC.
  assign bus.imem_addr    = imem_req_q ? bus.pc_addr : '0;
  assign bus.imem_req     = imem_req_q;
  assign bus.instr        = instr_q;
  assign bus.instr_valid  = instr_valid_q;
  assign bus.pc_en        = pc_en_q;
  assign bus.pc_branch_en = pc_branch_en_q;
  assign bus.pc_next_addr = pc_next_addr_q;
  assign bus.halted       = halted_q;
  assign bus.fault        = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench for instr_sequencer: memory and execute-unit responders push
// expectations derived from an architectural PC model; a monitor pops and compares them.
module tb_instr_sequencer;

  logic clk;
  logic rst;
`ifdef SEQ_SINGLE_STEP_EN
  logic step;
`endif

  instr_sequencer_if #(.ADDR_W(9), .INSTR_W(16)) bus ();

  instr_sequencer #(
    .ADDR_W  (9),
    .INSTR_W (16),
    .WAIT_MAX(15)
  ) dut (
    .clk (clk),
    .rst (rst),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Program counter driven by the sequencer.
  logic [8:0] pc;
  always @(posedge clk) begin
    if (rst) pc <= 9'd0;
    else if (bus.pc_en) pc <= bus.pc_branch_en ? bus.pc_next_addr : pc + 9'd1;
  end
  assign bus.pc_addr = pc;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [512];
  logic [8:0]  model_pc;
  logic [8:0]  fetch_q [$];
  logic [15:0] exp_instr_q [$];
  logic [9:0]  adv_q [$];
  int unsigned req_len_q [$];
  int unsigned pc_en_ts [$];
  int          pc_en_cnt = 0;
  int          req_rises = 0;

  int unsigned ack_min = 0, ack_max = 0, exec_min = 0, exec_max = 0, br_prob = 0;
  bit          mem_en = 1'b1;
  bit          oneshot_en = 1'b0;
  logic [8:0]  oneshot_tgt = 9'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic empty_fail(input string name, input logic [31:0] got);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h, expected nothing queued (cycle %0d)", name, got, cyc);
  endtask

  task automatic flush_model();
    fetch_q.delete();
    exp_instr_q.delete();
    adv_q.delete();
    req_len_q.delete();
    model_pc = 9'd0;
    fetch_q.push_back(9'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_imem_addr", bus.imem_addr, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_instr_valid", bus.instr_valid, 0);
    check("rst_pc_en", bus.pc_en, 0);
    check("rst_pc_branch_en", bus.pc_branch_en, 0);
    check("rst_pc_next_addr", bus.pc_next_addr, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_halted", bus.halted, 1);
  endtask

  // Caller is at a negedge; reset is held for two cycles.
  task automatic do_reset(input bit chk);
    rst = 1'b1;
    bus.run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    #1 flush_model();
    @(negedge clk);
    if (chk) check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pc_en(input int n, input int budget);
    int target;
    int k;
    target = pc_en_cnt + n;
    k = 0;
    while (pc_en_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_pc_en_timeout", pc_en_cnt >= target, 1);
  endtask

  // Instruction memory: random latency, stray acks outside FETCH.
  initial begin : mem_resp
    bit          busy;
    int unsigned wt;
    busy = 1'b0;
    wt = 0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 16'($urandom);
      if (rst) begin
        busy = 1'b0;
        continue;
      end
      if (mem_en && bus.imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          wt = $urandom_range(ack_max, ack_min);
          req_len_q.push_back(wt + 1);
        end
        if (wt == 0) begin
          bus.imem_ack = 1'b1;
          bus.imem_rdata = mem[bus.imem_addr];
          exp_instr_q.push_back(mem[model_pc]);
          busy = 1'b0;
        end else begin
          wt--;
        end
      end else if (!bus.imem_req) begin
        bus.imem_ack = ($urandom_range(3, 0) == 0);
      end
    end
  end

  // Execute unit: random latency and branch decisions; advances the architectural PC model.
  initial begin : exec_resp
    bit          pend;
    int unsigned wt;
    bit          br;
    logic [8:0]  tgt;
    pend = 1'b0;
    wt = 0;
    bus.exec_done = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    forever begin
      @(negedge clk);
      bus.exec_done = 1'b0;
      bus.br_taken = 1'($urandom);
      bus.br_target = 9'($urandom);
      if (rst) begin
        pend = 1'b0;
        continue;
      end
      if (bus.instr_valid) begin
        pend = 1'b1;
        wt = $urandom_range(exec_max, exec_min);
      end
      if (pend) begin
        if (wt == 0) begin
          if (oneshot_en) begin
            br = 1'b1;
            tgt = oneshot_tgt;
            oneshot_en = 1'b0;
          end else begin
            br = ($urandom_range(99, 0) < br_prob);
            tgt = 9'($urandom);
          end
          bus.exec_done = 1'b1;
          bus.br_taken = br;
          bus.br_target = tgt;
          adv_q.push_back({br, br ? tgt : 9'd0});
          model_pc = br ? tgt : model_pc + 9'd1;
          fetch_q.push_back(model_pc);
          pend = 1'b0;
        end else begin
          wt--;
        end
      end else begin
        bus.exec_done = ($urandom_range(3, 0) == 0);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a fetch, an instruction or a PC step.
  initial begin : monitor
    bit          req_p, iv_p, pe_p;
    int unsigned req_len;
    logic [8:0]  addr_hold;
    logic [9:0]  adv;
    req_p = 1'b0;
    iv_p = 1'b0;
    pe_p = 1'b0;
    req_len = 0;
    addr_hold = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_p = 1'b0;
        iv_p = 1'b0;
        pe_p = 1'b0;
        req_len = 0;
        continue;
      end
      if (bus.imem_req) begin
        if (!req_p) begin
          req_rises++;
          if (fetch_q.size() == 0) empty_fail("fetch_addr", bus.imem_addr);
          else check("fetch_addr", bus.imem_addr, fetch_q.pop_front());
          addr_hold = bus.imem_addr;
          req_len = 1;
        end else begin
          check("imem_addr_stable", bus.imem_addr, addr_hold);
          req_len++;
        end
      end else if (req_p && !bus.fault) begin
        if (req_len_q.size() == 0) empty_fail("req_cycles", req_len);
        else check("req_cycles", req_len, req_len_q.pop_front());
      end
      if (bus.instr_valid) begin
        check("instr_valid_pulse", iv_p, 0);
        if (exp_instr_q.size() == 0) empty_fail("instr", bus.instr);
        else check("instr", bus.instr, exp_instr_q.pop_front());
      end
      if (bus.pc_en) begin
        check("pc_en_pulse", pe_p, 0);
        pc_en_cnt++;
        pc_en_ts.push_back(cyc);
        if (adv_q.size() == 0) begin
          empty_fail("pc_advance", {bus.pc_branch_en, bus.pc_next_addr});
        end else begin
          adv = adv_q.pop_front();
          check("pc_branch_en", bus.pc_branch_en, adv[9]);
          check("pc_next_addr", bus.pc_next_addr, adv[8:0]);
        end
      end else begin
        check("pc_next_addr_idle", {bus.pc_branch_en, bus.pc_next_addr}, 0);
      end
      req_p = bus.imem_req;
      iv_p = bus.instr_valid;
      pe_p = bus.pc_en;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c;
    int n;
    int r;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    rst = 1'b1;
    bus.run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    @(negedge clk);
    do_reset(1'b1);

    // Back-to-back: immediate ack and exec_done, no branches -> pc_en every third cycle.
    ack_min = 0; ack_max = 0; exec_min = 0; exec_max = 0; br_prob = 0;
    pc_en_ts.delete();
    bus.run = 1'b1;
    wait_pc_en(4, 40);
    if (pc_en_ts.size() >= 4)
      for (int i = 1; i < 4; i++) check("throughput", pc_en_ts[i] - pc_en_ts[i-1], 3);

    // Forced branch to 0x1A0; the next fetch must use it.
    oneshot_tgt = 9'h1A0;
    oneshot_en = 1'b1;
    wait_pc_en(2, 40);

    // Late ack: req held for five cycles.
    ack_min = 4; ack_max = 4;
    wait_pc_en(2, 60);

    // Random latencies and branches.
    ack_min = 0; ack_max = 6; exec_min = 0; exec_max = 3; br_prob = 25;
    wait_pc_en(40, 800);

    // Drop run during EXEC: exactly one more pc_en, then idle with no new request.
    exec_min = 3; exec_max = 3;
    n = 0;
    while (!bus.instr_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("run_drop_exec_seen", bus.instr_valid, 1);
    bus.run = 1'b0;
    c = pc_en_cnt;
    r = req_rises;
    repeat (12) @(negedge clk);
    check("run_drop_one_pc_en", pc_en_cnt, c + 1);
    check("run_drop_no_req", req_rises, r);
    check("run_drop_halted", bus.halted, 1);
    check("run_drop_req_low", bus.imem_req, 0);

    // Reset in the middle of a fetch.
    ack_min = 8; ack_max = 8; exec_min = 0; exec_max = 2;
    bus.run = 1'b1;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_fetch_req_seen", bus.imem_req, 1);
    repeat (2) @(negedge clk);
    do_reset(1'b1);

    // Fetch timeout: exactly fifteen req cycles, then sticky fault that ignores run.
    mem_en = 1'b0;
    bus.run = 1'b1;
    n = 0;
    for (int k = 0; k < 60 && !bus.fault; k++) begin
      @(negedge clk);
      if (bus.imem_req) n++;
    end
    check("fault_req_cycles", n, 15);
    check("fault_flag", bus.fault, 1);
    check("fault_halted", bus.halted, 1);
    c = pc_en_cnt;
    repeat (10) begin
      @(negedge clk);
      bus.run = ~bus.run;
    end
    check("fault_sticky", bus.fault, 1);
    check("fault_req_low", bus.imem_req, 0);
    check("fault_no_pc_en", pc_en_cnt, c);
    do_reset(1'b0);
    @(negedge clk);
    check("fault_cleared", bus.fault, 0);
    check("fault_rst_halted", bus.halted, 1);
    mem_en = 1'b1;

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: each step pulse runs exactly one instruction.
    ack_min = 0; ack_max = 2; exec_min = 0; exec_max = 2; br_prob = 0;
    for (int s = 0; s < 2; s++) begin
      c = pc_en_cnt;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (12) @(negedge clk);
      check("step_one_pc_en", pc_en_cnt, c + 1);
      check("step_halted", bus.halted, 1);
      check("step_pc", pc, s + 1);
    end
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
